dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port byte-addressed data memory.
- Requester 0 is the core load/store stage; requester 1 is the debug/DMA port.
- Accepts one request at a time through a valid/ready handshake, drives the memory for exactly one access cycle, and returns read data with an error flag.
- Arbitration is round-robin (or fixed priority), with address-range checking before any write is committed.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and request record for the data-memory arbiter.
// Also holds the range check applied when a request is latched.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  // Last byte touched is computed in 33 bits so an access near 0xFFFFFFFF cannot wrap to a legal address.
  function automatic logic range_err(input logic [31:0] addr, input logic [1:0] size,
                                     input int abits);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + ((33'd1 << size) - 33'd1);
    return (size == SIZE_ILLEGAL) || (last_byte >= (33'd1 << abits));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input picker, purely combinational; one-hot grant.
// Round-robin favours the port that did not win last; fixed mode always favours port 0.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed_prio || last) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port data memory; accept -> 1 access cycle -> response pulse.
// One request in flight; ready is withheld during the access and while reset is high; no response back-pressure.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS  = 20,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic        req_we_0,
  input  logic        req_we_1,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_0,
  input  logic [31:0] req_wdata_1,
  input  logic [1:0]  req_size_0,
  input  logic [1:0]  req_size_1,
  input  logic        req_unsigned_0,
  input  logic        req_unsigned_1,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_data_size,
  output logic        mem_data_unsigned,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  state_t     state;
  logic       rr_last;
  logic [1:0] gnt;
  logic       win;
  logic       grant_q;
  logic       err_q;
  req_t       cur;
  req_t       req_q;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last       (rr_last),
    .fixed_prio (FIXED_PRIO != 0),
    .gnt        (gnt)
  );

  assign win = gnt[PORT_DMA];

  always_comb begin
    cur = '0;
    if (win) begin
      cur.we    = req_we_1;
      cur.addr  = req_addr_1;
      cur.wdata = req_wdata_1;
      cur.size  = req_size_1;
      cur.uns   = req_unsigned_1;
    end else begin
      cur.we    = req_we_0;
      cur.addr  = req_addr_0;
      cur.wdata = req_wdata_0;
      cur.size  = req_size_0;
      cur.uns   = req_unsigned_0;
    end
  end

  assign req_ready = (state == ST_IDLE && !rst) ? gnt : 2'b00;

  assign mem_address       = req_q.addr;
  assign mem_write_data    = req_q.wdata;
  assign mem_data_size     = req_q.size;
  assign mem_data_unsigned = req_q.uns;
  // Gated by rst as well so an aborted store cannot write at any edge while reset is held.
  assign mem_write_enable  = (state == ST_ACCESS) && req_q.we && !err_q && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_last    <= 1'b1;
      req_q      <= '0;
      err_q      <= 1'b0;
      grant_q    <= 1'b0;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_q   <= cur;
            err_q   <= range_err(cur.addr, cur.size, ADDR_BITS);
            grant_q <= win;
            rr_last <= win;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_rdata          <= (req_q.we || err_q) ? 32'h0 : mem_read_data;
          resp_err            <= err_q;
          resp_valid[grant_q] <= 1'b1;
          state               <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requests feed an expected-response queue drained by a monitor.
// A second instance with fixed priority shares the stimulus to observe its grant order.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready, f_req_ready;
  logic        req_we_0, req_we_1, req_unsigned_0, req_unsigned_1;
  logic [31:0] req_addr_0, req_addr_1, req_wdata_0, req_wdata_1;
  logic [1:0]  req_size_0, req_size_1;
  logic [1:0]  resp_valid, f_resp_valid;
  logic [31:0] resp_rdata, f_resp_rdata;
  logic        resp_err, f_resp_err;
  logic [31:0] mem_address, mem_write_data, f_mem_address, f_mem_write_data;
  logic [1:0]  mem_data_size, f_mem_data_size;
  logic        mem_data_unsigned, mem_write_enable, f_mem_data_unsigned, f_mem_write_enable;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_BITS(20), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we_0(req_we_0), .req_we_1(req_we_1), .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1), .req_size_0(req_size_0),
    .req_size_1(req_size_1), .req_unsigned_0(req_unsigned_0), .req_unsigned_1(req_unsigned_1),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_data_size(mem_data_size),
    .mem_data_unsigned(mem_data_unsigned), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.ADDR_BITS(20), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_we_0(req_we_0), .req_we_1(req_we_1), .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1), .req_size_0(req_size_0),
    .req_size_1(req_size_1), .req_unsigned_0(req_unsigned_0), .req_unsigned_1(req_unsigned_1),
    .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata), .resp_err(f_resp_err),
    .mem_address(f_mem_address), .mem_write_data(f_mem_write_data),
    .mem_data_size(f_mem_data_size), .mem_data_unsigned(f_mem_data_unsigned),
    .mem_write_enable(f_mem_write_enable), .mem_read_data(32'h0)
  );

  // Byte-addressed memory model, 2**20 bytes, combinational read with size/sign handling.
  logic [7:0]  mem [0:1048575];
  logic [19:0] ra;
  logic [7:0]  b0, b1, b2, b3;
  int          cyc = 0;
  int          we_cnt = 0;

  always_comb begin
    ra = mem_address[19:0];
    b0 = mem[ra];
    b1 = mem[ra + 20'd1];
    b2 = mem[ra + 20'd2];
    b3 = mem[ra + 20'd3];
    case (mem_data_size)
      SIZE_BYTE: mem_read_data = mem_data_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
      SIZE_HALF: mem_read_data = mem_data_unsigned ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default:   mem_read_data = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    cyc++;
    if (mem_write_enable) begin
      we_cnt++;
      mem[ra] = mem_write_data[7:0];
      if (mem_data_size != SIZE_BYTE) mem[ra + 20'd1] = mem_write_data[15:8];
      if (mem_data_size == SIZE_WORD) begin
        mem[ra + 20'd2] = mem_write_data[23:16];
        mem[ra + 20'd3] = mem_write_data[31:24];
      end
    end
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=%b expected none (t=%0t)", resp_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_port", {30'h0, resp_valid}, (mon_e.port == 1) ? 32'h2 : 32'h1);
        chk("resp_rdata", resp_rdata, mon_e.data);
        chk("resp_err", {31'h0, resp_err}, {31'h0, mon_e.err});
        chk("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic set_port(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    if (p == 0) begin
      req_we_0 = we; req_addr_0 = addr; req_wdata_0 = wdata; req_size_0 = size; req_unsigned_0 = uns;
    end else begin
      req_we_1 = we; req_addr_1 = addr; req_wdata_1 = wdata; req_size_1 = size; req_unsigned_1 = uns;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input bit want, input logic [31:0] ed, input logic ee, output int acc);
    int n;
    n = 0;
    set_port(p, we, addr, wdata, size, uns);
    req_valid[p] = 1'b1;
    @(negedge clk);
    while (!req_ready[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[p]) begin
      chk("accept_timeout", {31'h0, req_ready[p]}, 32'h1);
      req_valid[p] = 1'b0;
      acc = -1;
    end else begin
      if (want) sb.push_back('{p, ed, ee, cyc + 2});
      acc = cyc;
      @(posedge clk);
      #1;
      req_valid[p] = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, w0, k;
    rst = 1'b1;
    req_valid = 2'b11;
    set_port(0, 1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0);
    set_port(1, 1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {30'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load a word on port 0.
    w0 = we_cnt;
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, SIZE_WORD, 1'b0, 1'b1, 32'h0, 1'b0, a0);
    settle(3);
    chk("store_we_cycles", we_cnt - w0, 32'd1);
    issue(0, 1'b0, 32'h100, 32'h0, SIZE_WORD, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, a0);

    // Port 1 byte store then signed/unsigned byte loads; plus preloads for later tests.
    issue(1, 1'b1, 32'h200, 32'h00000080, SIZE_BYTE, 1'b0, 1'b1, 32'h0, 1'b0, a0);
    issue(1, 1'b0, 32'h200, 32'h0, SIZE_BYTE, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, a0);
    issue(1, 1'b0, 32'h200, 32'h0, SIZE_BYTE, 1'b1, 1'b1, 32'h00000080, 1'b0, a0);
    issue(0, 1'b1, 32'h000FFFFE, 32'h00002211, SIZE_HALF, 1'b0, 1'b1, 32'h0, 1'b0, a0);
    issue(0, 1'b1, 32'h300, 32'hAABBCCDD, SIZE_WORD, 1'b0, 1'b1, 32'h0, 1'b0, a0);
    settle(3);

    // Conflict after reset: round-robin 0,1,0,1; fixed priority always port 0.
    rst = 1'b1;
    settle(1);
    rst = 1'b0;
    set_port(0, 1'b0, 32'h100, 32'h0, SIZE_WORD, 1'b0);
    set_port(1, 1'b0, 32'h200, 32'h0, SIZE_BYTE, 1'b1);
    req_valid = 2'b11;
    for (k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", {30'h0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("fixed_grant", {30'h0, f_req_ready}, 32'h1);
      if (k % 2 == 0) sb.push_back('{0, 32'hDEADBEEF, 1'b0, cyc + 2});
      else            sb.push_back('{1, 32'h00000080, 1'b0, cyc + 2});
      @(negedge clk);
      chk("access_ready_low", {30'h0, req_ready}, 32'h0);
    end
    req_valid = 2'b00;
    settle(3);

    // Range and illegal-size errors, with in-range boundary and 33-bit no-wrap cases.
    w0 = we_cnt;
    issue(0, 1'b1, 32'h000FFFFE, 32'h55667788, SIZE_WORD, 1'b0, 1'b1, 32'h0, 1'b1, a0);
    issue(0, 1'b0, 32'h100, 32'h0, SIZE_ILLEGAL, 1'b0, 1'b1, 32'h0, 1'b1, a0);
    issue(1, 1'b0, 32'h000FFFFF, 32'h0, SIZE_BYTE, 1'b1, 1'b1, 32'h00000022, 1'b0, a0);
    issue(1, 1'b0, 32'hFFFFFFFF, 32'h0, SIZE_BYTE, 1'b0, 1'b1, 32'h0, 1'b1, a0);
    settle(3);
    chk("err_no_write", we_cnt - w0, 32'd0);
    chk("err_mem_fffffe", {24'h0, mem[20'hFFFFE]}, 32'h11);
    chk("err_mem_fffff", {24'h0, mem[20'hFFFFF]}, 32'h22);

    // Reset asserted during the access cycle of a store.
    w0 = we_cnt;
    issue(0, 1'b1, 32'h300, 32'h12345678, SIZE_WORD, 1'b0, 1'b0, 32'h0, 1'b0, a0);
    rst = 1'b1;
    #1;
    chk("rst_async_we", {31'h0, mem_write_enable}, 32'h0);
    req_valid[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ready", {30'h0, req_ready}, 32'h0);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    settle(3);
    chk("rst_no_write", we_cnt - w0, 32'd0);
    chk("rst_mem_300", {mem[20'h303], mem[20'h302], mem[20'h301], mem[20'h300]}, 32'hAABBCCDD);

    // Back-to-back loads on port 0: one accept every two cycles.
    issue(0, 1'b0, 32'h100, 32'h0, SIZE_WORD, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, a0);
    issue(0, 1'b0, 32'h200, 32'h0, SIZE_BYTE, 1'b1, 1'b1, 32'h00000080, 1'b0, a1);
    issue(0, 1'b0, 32'h300, 32'h0, SIZE_HALF, 1'b0, 1'b1, 32'hFFFFCCDD, 1'b0, a2);
    chk("b2b_gap1", a1 - a0, 32'd2);
    chk("b2b_gap2", a2 - a1, 32'd2);
    settle(5);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
